// File: rtl/uart_instr_loader_if.sv
// Byte stream from the UART receiver and the instruction-memory write port.
// The loader takes the master view; the UART/memory side takes the slave view.
interface uart_instr_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              uart_rx_valid;
  logic [7:0]        uart_rx_data;
  logic              uart_rx_break;
  logic              uart_rx_en;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_wr_addr;
  logic [31:0]       imem_wr_data;

  modport master (
    input  uart_rx_valid, uart_rx_data, uart_rx_break,
    output uart_rx_en, imem_wr_en, imem_wr_addr, imem_wr_data
  );

  modport slave (
    output uart_rx_valid, uart_rx_data, uart_rx_break,
    input  uart_rx_en, imem_wr_en, imem_wr_addr, imem_wr_data
  );
endinterface

// File: rtl/uart_instr_loader.sv
// Packs UART bytes into little-endian 32-bit instruction words, writes them to
// instruction memory and releases the core from reset once loading completes.
module uart_instr_loader #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  reload,
  uart_instr_loader_if.master   bus,
  output logic [ADDR_W:0]       word_count,
  output logic                  load_done,
  output logic                  sync_err,
  output logic                  core_rst_n
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W:0]   LAST_WORD = (ADDR_W + 1)'((1 << ADDR_W) - 1);

  typedef enum logic {
    LOAD = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [23:0]       shift;
  logic [IDLE_W-1:0] idle_cnt;

  logic            write_now;
  logic            full_now;
  logic            partial_after;
  logic [ADDR_W:0] words_after;

  // What this edge's byte (if any) does, so a same-edge break sees its result.
  always_comb begin
    write_now     = 1'b0;
    full_now      = 1'b0;
    partial_after = 1'b0;
    words_after   = word_count;
    if (state == LOAD) begin
      write_now     = bus.uart_rx_valid && (byte_cnt == 2'd3);
      full_now      = write_now && (word_count == LAST_WORD);
      partial_after = bus.uart_rx_valid ? (byte_cnt != 2'd3) : (byte_cnt != 2'd0);
      words_after   = word_count + {{ADDR_W{1'b0}}, write_now};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= LOAD;
      byte_cnt         <= 2'd0;
      shift            <= 24'd0;
      idle_cnt         <= '0;
      bus.imem_wr_en   <= 1'b0;
      bus.imem_wr_addr <= '0;
      bus.imem_wr_data <= 32'd0;
      bus.uart_rx_en   <= 1'b1;
      word_count       <= '0;
      load_done        <= 1'b0;
      sync_err         <= 1'b0;
      core_rst_n       <= 1'b0;
    end else begin
      bus.imem_wr_en <= 1'b0;
      if (reload) begin
        state          <= LOAD;
        byte_cnt       <= 2'd0;
        shift          <= 24'd0;
        idle_cnt       <= '0;
        word_count     <= '0;
        load_done      <= 1'b0;
        sync_err       <= 1'b0;
        core_rst_n     <= 1'b0;
        bus.uart_rx_en <= 1'b1;
      end else if (state == LOAD) begin
        if (bus.uart_rx_valid) begin
          idle_cnt <= '0;
          if (byte_cnt != 2'd3) begin
            shift[{byte_cnt, 3'b000} +: 8] <= bus.uart_rx_data;
            byte_cnt <= byte_cnt + 2'd1;
          end else begin
            bus.imem_wr_data <= {bus.uart_rx_data, shift};
            bus.imem_wr_addr <= word_count[ADDR_W-1:0];
            bus.imem_wr_en   <= 1'b1;
            word_count       <= words_after;
            byte_cnt         <= 2'd0;
            shift            <= 24'd0;
          end
        end else if (byte_cnt != 2'd0) begin
          // A stalled partial word is dropped so the next byte starts a fresh word.
          if (idle_cnt == IDLE_MAX) begin
            byte_cnt <= 2'd0;
            shift    <= 24'd0;
            idle_cnt <= '0;
            sync_err <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end else begin
          idle_cnt <= '0;
        end

        if (bus.uart_rx_break && partial_after) begin
          byte_cnt <= 2'd0;
          shift    <= 24'd0;
          idle_cnt <= '0;
          sync_err <= 1'b1;
        end

        if (full_now || (bus.uart_rx_break && (words_after != '0))) begin
          state          <= DONE;
          load_done      <= 1'b1;
          core_rst_n     <= 1'b1;
          bus.uart_rx_en <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_instr_loader.sv
// Directed bench for uart_instr_loader: small memory and short timeout so the
// full-memory and idle-timeout paths are reachable in a few hundred cycles.
module tb_uart_instr_loader;

  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 20;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            reload = 1'b0;
  logic [ADDR_W:0] word_count;
  logic            load_done;
  logic            sync_err;
  logic            core_rst_n;

  int vectors     = 0;
  int miscompares = 0;
  int wrCount     = 0;

  uart_instr_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_instr_loader #(
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .reload(reload),
    .bus(bus),
    .word_count(word_count),
    .load_done(load_done),
    .sync_err(sync_err),
    .core_rst_n(core_rst_n)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.imem_wr_en === 1'b1) wrCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; returns just after the sampling edge.
  task automatic applyStimulus(input logic vld, input logic [7:0] data, input logic brk, input logic rld);
    @(negedge clk);
    bus.uart_rx_valid = vld;
    bus.uart_rx_data  = data;
    bus.uart_rx_break = brk;
    reload            = rld;
    @(posedge clk);
    #1;
    bus.uart_rx_valid = 1'b0;
    bus.uart_rx_data  = 8'h00;
    bus.uart_rx_break = 1'b0;
    reload            = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendWord(input string tag, input logic [31:0] w, input logic [ADDR_W-1:0] addr,
                          input logic brkLast);
    applyStimulus(1'b1, w[7:0],   1'b0, 1'b0);
    applyStimulus(1'b1, w[15:8],  1'b0, 1'b0);
    applyStimulus(1'b1, w[23:16], 1'b0, 1'b0);
    applyStimulus(1'b1, w[31:24], brkLast, 1'b0);
    checkOutput({tag, ".wr_en"}, 32'(bus.imem_wr_en), 32'd1);
    checkOutput({tag, ".addr"},  32'(bus.imem_wr_addr), 32'(addr));
    checkOutput({tag, ".data"},  bus.imem_wr_data, w);
  endtask

  initial begin
    int wrBefore;
    bus.uart_rx_valid = 1'b0;
    bus.uart_rx_data  = 8'h00;
    bus.uart_rx_break = 1'b0;

    #12;
    checkOutput("rst.wr_en",  32'(bus.imem_wr_en), 32'd0);
    checkOutput("rst.addr",   32'(bus.imem_wr_addr), 32'd0);
    checkOutput("rst.data",   bus.imem_wr_data, 32'd0);
    checkOutput("rst.wc",     32'(word_count), 32'd0);
    checkOutput("rst.done",   32'(load_done), 32'd0);
    checkOutput("rst.err",    32'(sync_err), 32'd0);
    checkOutput("rst.core",   32'(core_rst_n), 32'd0);
    checkOutput("rst.rx_en",  32'(bus.uart_rx_en), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    idle(3);
    checkOutput("post_rst.core", 32'(core_rst_n), 32'd0);
    checkOutput("post_rst.wc",   32'(word_count), 32'd0);

    sendWord("single", 32'hFE010113, 2'd0, 1'b0);
    checkOutput("single.wc", 32'(word_count), 32'd1);
    idle(1);
    checkOutput("single.pulse_end", 32'(bus.imem_wr_en), 32'd0);
    checkOutput("single.wrs", 32'(wrCount), 32'd1);

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("reload1.wc", 32'(word_count), 32'd0);
    sendWord("three0", 32'hFE010113, 2'd0, 1'b0);
    sendWord("three1", 32'h00812E23, 2'd1, 1'b0);
    sendWord("three2", 32'h02010413, 2'd2, 1'b0);
    checkOutput("three.done_before_brk", 32'(load_done), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("three.done",  32'(load_done), 32'd1);
    checkOutput("three.core",  32'(core_rst_n), 32'd1);
    checkOutput("three.rx_en", 32'(bus.uart_rx_en), 32'd0);
    checkOutput("three.err",   32'(sync_err), 32'd0);
    checkOutput("three.wc",    32'(word_count), 32'd3);

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("reload2.done",  32'(load_done), 32'd0);
    checkOutput("reload2.core",  32'(core_rst_n), 32'd0);
    checkOutput("reload2.wc",    32'(word_count), 32'd0);
    checkOutput("reload2.rx_en", 32'(bus.uart_rx_en), 32'd1);

    idle(1);
    wrBefore = wrCount;
    applyStimulus(1'b1, 8'h13, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
    idle(TIMEOUT - 1);
    checkOutput("timeout.err_early", 32'(sync_err), 32'd0);
    idle(1);
    checkOutput("timeout.err", 32'(sync_err), 32'd1);
    checkOutput("timeout.nowrite", 32'(wrCount - wrBefore), 32'd0);
    sendWord("after_to", 32'h00500793, 2'd0, 1'b0);
    checkOutput("after_to.err_sticky", 32'(sync_err), 32'd1);

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    sendWord("full0", 32'h11223344, 2'd0, 1'b0);
    sendWord("full1", 32'h55667788, 2'd1, 1'b0);
    sendWord("full2", 32'h99AABBCC, 2'd2, 1'b0);
    checkOutput("full.not_yet", 32'(load_done), 32'd0);
    sendWord("full3", 32'hDDEEFF00, 2'd3, 1'b0);
    checkOutput("full.done", 32'(load_done), 32'd1);
    checkOutput("full.wc",   32'(word_count), 32'd4);
    idle(1);
    wrBefore = wrCount;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);
    checkOutput("done.nowrite", 32'(wrCount - wrBefore), 32'd0);
    checkOutput("done.wc",      32'(word_count), 32'd4);
    checkOutput("done.rx_en",   32'(bus.uart_rx_en), 32'd0);

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("reload3.done", 32'(load_done), 32'd0);
    sendWord("reload3", 32'hCAFEF00D, 2'd0, 1'b0);

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("brk0.done",  32'(load_done), 32'd0);
    checkOutput("brk0.rx_en", 32'(bus.uart_rx_en), 32'd1);
    checkOutput("brk0.err",   32'(sync_err), 32'd0);

    applyStimulus(1'b1, 8'h13, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("brk_partial.err",  32'(sync_err), 32'd1);
    checkOutput("brk_partial.done", 32'(load_done), 32'd0);
    sendWord("brk_partial", 32'h00812E23, 2'd0, 1'b0);

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    sendWord("vb_same", 32'h02010413, 2'd0, 1'b1);
    checkOutput("vb_same.done", 32'(load_done), 32'd1);
    checkOutput("vb_same.err",  32'(sync_err), 32'd0);

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);
    wrBefore = wrCount;
    applyStimulus(1'b1, 8'h93, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h07, 1'b0, 1'b0);
    @(negedge clk);
    resetn = 1'b0;
    #2;
    checkOutput("midrst.core", 32'(core_rst_n), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    idle(2);
    checkOutput("midrst.nowrite", 32'(wrCount - wrBefore), 32'd0);
    checkOutput("midrst.wc",      32'(word_count), 32'd0);
    sendWord("midrst", 32'h00500793, 2'd0, 1'b0);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_instr_loader.md
Name: uart_instr_loader

Overview:
Downstream consumer of the UART receiver in the boot-load path. It packs the byte stream (uart_rx_valid/uart_rx_data) into 32-bit little-endian RISC-V instruction words and writes them sequentially into instruction memory. It holds the core in reset until loading completes, then releases it. A load completes on a UART BREAK, or when memory is full.

Parameters:
ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words.
TIMEOUT_CYCLES, 50000, idle clk cycles allowed mid-word before the partial word is discarded (1 ms at 50 MHz).

Ports:
clk  input  1  system clock; all state updates on rising edge.
resetn  input  1  asynchronous active-low reset.
uart_rx_valid  input  1  one-cycle strobe, received byte valid.
uart_rx_data  input  8  received byte; sampled only when uart_rx_valid=1.
uart_rx_break  input  1  one-cycle strobe, BREAK detected.
reload  input  1  one-cycle strobe; restarts a load from address 0.
uart_rx_en  output  1  receive enable to the UART; 1 while not DONE.
imem_wr_en  output  1  one-cycle instruction-memory write strobe.
imem_wr_addr  output  ADDR_W  word address of the write.
imem_wr_data  output  32  assembled instruction.
word_count  output  ADDR_W+1  number of words written this load.
load_done  output  1  level, load complete.
sync_err  output  1  sticky, a partial word was discarded (timeout or break).
core_rst_n  output  1  active-low core reset; 0 until DONE.

Behaviour:
- Reset (resetn=0, asynchronous):
  - State becomes LOAD, byte_cnt=0, shift=0, idle_cnt=0.
  - imem_wr_en=0, imem_wr_addr=0, imem_wr_data=0, word_count=0.
  - load_done=0, sync_err=0, core_rst_n=0, uart_rx_en=1.
- State machine has two states, LOAD and DONE. The state is held in registers; all outputs are registered.
- LOAD, on uart_rx_valid:
  - If byte_cnt<3: byte goes to shift[8*byte_cnt+:8], byte_cnt++, idle_cnt=0.
  - If byte_cnt==3: on the same edge imem_wr_data<={byte,shift[23:0]}, imem_wr_addr<=word_count[ADDR_W-1:0], imem_wr_en<=1, word_count++, byte_cnt<=0.
  - Latency: imem_wr_en is high in the cycle after the edge that sampled the 4th byte, for exactly one cycle. There is no backpressure; memory accepts every strobe.
- Byte order: first received byte is bits [7:0], fourth is bits [31:24].
- Idle timeout: applies only while byte_cnt!=0. idle_cnt increments each cycle without valid. When it reaches TIMEOUT_CYCLES-1, byte_cnt<=0, shift<=0, sync_err<=1, and no write occurs. While byte_cnt==0, idle_cnt is held at 0.
- uart_rx_break in LOAD:
  - If byte_cnt!=0, the partial word is discarded and sync_err<=1.
  - If word_count (including a write committed on the same edge) is nonzero, go to DONE.
  - Otherwise stay in LOAD with byte_cnt=0.
- Full: when the write that makes word_count==2^ADDR_W commits, go to DONE on the same edge.
- Simultaneous valid and break on the same edge: the byte is processed first, then the break is applied.
- DONE:
  - load_done=1, core_rst_n=1, uart_rx_en=0.
  - uart_rx_valid and uart_rx_break are ignored; no writes occur.
- reload (any state):
  - Go to LOAD; byte_cnt, word_count, idle_cnt, sync_err, load_done cleared; core_rst_n=0, uart_rx_en=1.
  - reload has priority over valid/break on the same edge. Memory contents are not cleared.
- Reset mid-word: the partial word is lost and no write is issued. Upstream must resend from word 0.
- word_count never wraps; addresses stay within 0..2^ADDR_W-1.

Test Plan:
- Reset: hold resetn=0 -> all outputs at reset values, core_rst_n=0, uart_rx_en=1. Deassert -> unchanged until the first byte.
- Single word: bytes 13,01,01,FE -> one imem_wr_en pulse the cycle after the 4th byte, addr 0, data FE010113, word_count=1.
- Three words (FE010113, 00812E23, 02010413), then break -> writes at addr 0,1,2; load_done=1, core_rst_n=1, uart_rx_en=0, sync_err=0.
- Partial word: bytes 13,01, then TIMEOUT_CYCLES idle -> sync_err=1, no write. Bytes 93,07,50,00 -> write 00500793 at addr 0.
- Full (ADDR_W=2): 16 bytes -> 4 writes at addr 0..3, DONE after the 4th. Further bytes and break -> no writes, word_count stays 4.
- Reload and break edge cases: after DONE, pulse reload -> load_done=0, core_rst_n=0, word_count=0; next word writes addr 0. Break with 0 words -> remains LOAD. Reset after 2 bytes -> no write.
